// File: rtl/ahblite_decode_mux_if.sv
// AHB-Lite decode/mux bus bundle.
// Carries the master address phase, the per-slave select and response
// vectors, the muxed response back to the master, and the unmapped-access
// error log.
// The slave modport is the decoder's view; the master modport is the view
// of whatever drives addresses and models the slaves.
interface ahblite_decode_mux_if #(
  parameter int NPORT = 5
);
  logic [31:0]         HADDR;
  logic [1:0]          HTRANS;
  logic [NPORT-1:0]    HSEL_P;
  logic [NPORT-1:0]    HREADYOUT_P;
  logic [NPORT-1:0]    HRESP_P;
  logic [32*NPORT-1:0] HRDATA_P;
  logic                HREADY;
  logic                HRESP;
  logic [31:0]         HRDATA;
  logic [7:0]          ERR_CNT;
  logic [31:0]         ERR_ADDR;

  modport slave (
    input  HADDR,
    input  HTRANS,
    input  HREADYOUT_P,
    input  HRESP_P,
    input  HRDATA_P,
    output HSEL_P,
    output HREADY,
    output HRESP,
    output HRDATA,
    output ERR_CNT,
    output ERR_ADDR
  );

  modport master (
    output HADDR,
    output HTRANS,
    output HREADYOUT_P,
    output HRESP_P,
    output HRDATA_P,
    input  HSEL_P,
    input  HREADY,
    input  HRESP,
    input  HRDATA,
    input  ERR_CNT,
    input  ERR_ADDR
  );
endinterface

// File: rtl/ahblite_decode_mux.sv
// AHB-Lite address decoder, response multiplexer and default slave.
//
// Each address phase is compared against every port's masked base address.
// When several ports match, the lowest-numbered one wins, so the select
// vector is one-hot or zero.
//
// The data-phase selector is a registered one-hot copy of the select vector.
// It advances only when HREADY is high. An all-zero selector means the
// built-in default slave owns the data phase.
//
// The default slave answers IDLE/BUSY with a zero-wait OKAY. It answers an
// active transfer with the standard two-cycle ERROR, and it logs the failing
// address and a saturating count of such transfers.
module ahblite_decode_mux #(
  parameter int                  NPORT     = 5,
  parameter logic [NPORT-1:0]    PORT_EN   = 5'b01011,
  parameter logic [32*NPORT-1:0] PORT_BASE = {32'h40050000, 32'h40000010,
                                              32'h40000000, 32'h20000000,
                                              32'h00000000},
  parameter logic [32*NPORT-1:0] PORT_MASK = {32'hFFFF0000, 32'hFFFFFFF0,
                                              32'hFFFFFFF0, 32'hFFFF0000,
                                              32'hFFFF0000}
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahblite_decode_mux_if.slave bus
);

  typedef enum logic [1:0] {
    D_OK   = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dState_t;

  dState_t          r_state;
  dState_t          w_nextState;
  logic [NPORT-1:0] r_dpSel;
  logic [NPORT-1:0] w_nextDpSel;
  logic [7:0]       r_errCnt;
  logic [31:0]      r_errAddr;
  logic             w_errEntry;

  logic [NPORT-1:0] w_hit;
  logic [NPORT-1:0] w_sel;
  logic             w_found;
  logic             w_anyHit;

  logic             w_hready;
  logic             w_hresp;
  logic [31:0]      w_hrdata;

  // Raw per-port address match; a disabled port can never match
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NPORT; i++) begin
      w_hit[i] = PORT_EN[i] &&
                 ((bus.HADDR & PORT_MASK[32*i +: 32]) ==
                  (PORT_BASE[32*i +: 32] & PORT_MASK[32*i +: 32]));
    end
  end

  // Keep only the lowest-index match so that overlapping windows resolve deterministically
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (w_hit[i] && !w_found) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign w_anyHit   = |w_sel;
  assign bus.HSEL_P = w_sel;

  // Route the data-phase owner's response to the master; the default slave answers from its FSM state
  always_comb begin
    w_hready = 1'b1;
    w_hresp  = 1'b0;
    w_hrdata = '0;
    if (!HRESETn) begin
      w_hready = 1'b1;
      w_hresp  = 1'b0;
      w_hrdata = '0;
    end else if (|r_dpSel) begin
      for (int i = 0; i < NPORT; i++) begin
        if (r_dpSel[i]) begin
          w_hready = bus.HREADYOUT_P[i];
          w_hresp  = bus.HRESP_P[i];
          w_hrdata = bus.HRDATA_P[32*i +: 32];
        end
      end
    end else begin
      case (r_state)
        D_ERR1: begin
          w_hready = 1'b0;
          w_hresp  = 1'b1;
        end
        D_ERR2: begin
          w_hready = 1'b1;
          w_hresp  = 1'b1;
        end
        default: begin
          w_hready = 1'b1;
          w_hresp  = 1'b0;
        end
      endcase
    end
  end

  assign bus.HREADY   = w_hready;
  assign bus.HRESP    = w_hresp;
  assign bus.HRDATA   = w_hrdata;
  assign bus.ERR_CNT  = r_errCnt;
  assign bus.ERR_ADDR = r_errAddr;

  // Next data-phase owner and default-slave state, decided only when the bus accepts an address phase
  always_comb begin
    w_nextState = r_state;
    w_nextDpSel = r_dpSel;
    w_errEntry  = 1'b0;
    if (r_state == D_ERR1) begin
      w_nextState = D_ERR2;
    end else if (w_hready) begin
      w_nextDpSel = w_sel;
      if (w_anyHit) begin
        w_nextState = D_OK;
      end else if (bus.HTRANS[1]) begin
        w_nextState = D_ERR1;
        w_errEntry  = 1'b1;
      end else begin
        w_nextState = D_OK;
      end
    end
  end

  // State register for the data-phase selector and default-slave FSM
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= D_OK;
      r_dpSel <= '0;
    end else begin
      r_state <= w_nextState;
      r_dpSel <= w_nextDpSel;
    end
  end

  // Log every unmapped active transfer as it enters the first error cycle
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_errCnt  <= '0;
      r_errAddr <= '0;
    end else if (w_errEntry) begin
      r_errAddr <= bus.HADDR;
      if (r_errCnt != 8'hFF) begin
        r_errCnt <= r_errCnt + 8'd1;
      end
    end
  end

endmodule
